shift_sequencer: RTL and testbench

Multi-cycle logical shift stage that sits directly upstream of the single-step ShiftLeft/ShiftRight registers. It accepts an N-bit word, a direction and a shift amount over a valid/ready handshake. It shifts the word one bit position per clock until the amount is exhausted, then presents the result, with a lost-bit flag, on a second valid/ready handshake. All shifts are logical and zero-filled, for unsigned data.

---
 rtl/shift_sequencer.sv | 108 ++++++++++
 tb/tb_shift_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle logical shifter, one bit position per clock.
// Takes a word, direction and amount over a valid/ready handshake, shifts it
// with zero fill and presents the result plus a lost-bit flag on a second
// valid/ready handshake.
module shift_sequencer #(
    parameter int N     = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     data_i,
    input  logic             dir_i,
    input  logic [AMT_W-1:0] amt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     data_o,
    output logic             lost_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] N_AMT = AMT_W'(N);

    state_t           state;
    logic [N-1:0]     work;
    logic [AMT_W-1:0] cnt;
    logic             dir;
    logic             lost;
    logic             out_valid;
    logic             busy;
    logic [AMT_W-1:0] amt_clamped;

    // Amounts beyond the word width all produce the same all-zero result.
    assign amt_clamped = (amt_i > N_AMT) ? N_AMT : amt_i;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign in_ready_o  = (state == IDLE) && rst_i;
    assign data_o      = work;
    assign lost_o      = lost;
    assign out_valid_o = out_valid;
    assign busy_o      = busy;

    // Sequencer: accept, shift one bit per edge, hold result until consumed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            lost      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        work <= data_i;
                        dir  <= dir_i;
                        cnt  <= amt_clamped;
                        lost <= 1'b0;
                        busy <= 1'b1;
                        if (amt_clamped == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // The bit leaving the word is the MSB for left, LSB for right.
                    if (dir) begin
                        work <= work >> 1;
                        lost <= lost | work[0];
                    end else begin
                        work <= work << 1;
                        lost <= lost | work[N-1];
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with hand-computed expectations.
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic       dir;
    logic [3:0] amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       lost;
    logic       busy;

    int tests = 0;
    int fails = 0;

    shift_sequencer #(.N(8), .AMT_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data_in),
        .dir_i       (dir),
        .amt_i       (amt),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_out),
        .lost_o      (lost),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a negedge, let one posedge accept it, return at the next negedge.
    task automatic accept(input logic [7:0] d, input logic r, input logic [3:0] a);
        data_in  = d;
        dir      = r;
        amt      = a;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges since the accepting edge until out_valid rises (bounded).
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; data_in = 8'hFF; dir = 1'b0; amt = 4'd3; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
                data_out !== 8'h00 || lost !== 1'b0) begin
                fails++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b vld=%b busy=%b data=%h lost=%b want all 0",
                         i, in_ready, out_valid, busy, data_out, lost);
            end
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_left_right();
        int e;
        out_ready = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL lr_ready_before: got %b want 1", in_ready);
        end
        accept(8'b10101010, 1'b0, 4'd1);
        wait_valid(e);
        tests++;
        if (e != 2 || data_out !== 8'b01010100 || lost !== 1'b1) begin
            fails++;
            $display("FAIL left1: got edges=%0d data=%b lost=%b want edges=2 data=01010100 lost=1", e, data_out, lost);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL left1_xfer: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        accept(8'b01010101, 1'b1, 4'd3);
        wait_valid(e);
        tests++;
        if (e != 4 || data_out !== 8'b00001010 || lost !== 1'b1) begin
            fails++;
            $display("FAIL right3: got edges=%0d data=%b lost=%b want edges=4 data=00001010 lost=1", e, data_out, lost);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_clamp();
        int e;
        out_ready = 1'b1;
        accept(8'b11110000, 1'b0, 4'd0);
        wait_valid(e);
        tests++;
        if (e != 1 || data_out !== 8'b11110000 || lost !== 1'b0) begin
            fails++;
            $display("FAIL amt0: got edges=%0d data=%b lost=%b want edges=1 data=11110000 lost=0", e, data_out, lost);
        end
        @(negedge clk);
        accept(8'b00001111, 1'b1, 4'd12);
        wait_valid(e);
        tests++;
        if (e != 9 || data_out !== 8'h00 || lost !== 1'b1) begin
            fails++;
            $display("FAIL clamp12: got edges=%0d data=%b lost=%b want edges=9 data=00000000 lost=1", e, data_out, lost);
        end
        @(negedge clk);
        accept(8'h00, 1'b0, 4'd15);
        wait_valid(e);
        tests++;
        if (e != 9 || data_out !== 8'h00 || lost !== 1'b0) begin
            fails++;
            $display("FAIL clamp_zero_operand: got edges=%0d data=%b lost=%b want edges=9 data=0 lost=0", e, data_out, lost);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int e;
        out_ready = 1'b0;
        accept(8'b00001111, 1'b0, 4'd4);
        wait_valid(e);
        tests++;
        if (e != 5) begin
            fails++;
            $display("FAIL bp_latency: got %0d edges want 5", e);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (out_valid !== 1'b1 || data_out !== 8'b11110000 || lost !== 1'b0 ||
                in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got vld=%b data=%b lost=%b rdy=%b busy=%b want 1 11110000 0 0 1",
                         i, out_valid, data_out, lost, in_ready, busy);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_input_stability();
        int e;
        out_ready = 1'b1;
        accept(8'b10000001, 1'b1, 4'd3);
        data_in  = 8'hFF;
        dir      = 1'b0;
        amt      = 4'd1;
        in_valid = 1'b1;
        wait_valid(e);
        tests++;
        if (e != 4 || data_out !== 8'b00010000 || lost !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stability: got edges=%0d data=%b lost=%b rdy=%b want edges=4 data=00010000 lost=1 rdy=0",
                     e, data_out, lost, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stability_no_reaccept: got busy=%b vld=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        int e;
        out_ready = 1'b1;
        accept(8'hFF, 1'b0, 4'd5);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || data_out !== 8'h00 || lost !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got vld=%b data=%h lost=%b busy=%b rdy=%b want all 0",
                     out_valid, data_out, lost, busy, in_ready);
        end
        rst = 1'b1;
        accept(8'b00111100, 1'b1, 4'd2);
        wait_valid(e);
        tests++;
        if (e != 3 || data_out !== 8'b00001111 || lost !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_op: got edges=%0d data=%b lost=%b want edges=3 data=00001111 lost=0", e, data_out, lost);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; data_in = '0; dir = 1'b0; amt = '0; out_ready = 1'b0;
        test_reset();
        test_left_right();
        test_zero_clamp();
        test_backpressure();
        test_input_stability();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
